// File: rtl/byte_bus_bridge.sv
// Serialises the core's 32-bit memory steps into byte-wide SRAM transactions, gating the core with core_ce.
// Optional one-word read cache: define BYTE_BUS_BRIDGE_FETCH_CACHE_EN.
module byte_bus_bridge #(
   parameter int ADDR_W      = 20,
   parameter int WAIT_STATES = 1
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic [31:0]       core_a,
   input  logic [31:0]       core_o,
   input  logic [1:0]        core_ws,
   input  logic              core_w,
   output logic [31:0]       core_i,
   output logic              core_ce,
   output logic [ADDR_W-1:0] mem_a,
   output logic [7:0]        mem_dout,
   input  logic [7:0]        mem_din,
   output logic              mem_we
);
   // state  | meaning
   // S_IDLE | latch core request, one cycle
   // S_BYTE | one byte phase per (1+WAIT_STATES) cycles
   // S_ACK  | core_ce pulse, core advances on this edge
   typedef enum logic [1:0] {S_IDLE, S_BYTE, S_ACK} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] base;
   logic [31:0]       data;
   logic [31:0]       asm_word, asm_nxt;
   logic              wr;
   logic [1:0]        idx, last_idx;
   logic [3:0]        wait_cnt;
   logic              phase_end, last_byte;
   logic              hit;
   logic [31:0]       hit_word;
   logic              unused_core_a;

   assign unused_core_a = ^core_a[31:ADDR_W];

   assign phase_end = (wait_cnt == 4'd0);
   assign last_byte = phase_end && (idx == last_idx);

   assign mem_a    = base + ADDR_W'(idx);
   assign mem_dout = data[8*idx +: 8];
   assign mem_we   = (state == S_BYTE) && wr;
   assign core_ce  = (state == S_ACK);

`ifdef BYTE_BUS_BRIDGE_FETCH_CACHE_EN
   logic              cache_valid;
   logic [ADDR_W-1:0] cache_tag;
   logic [31:0]       cache_word;

   assign hit      = !core_w && cache_valid && (cache_tag == core_a[ADDR_W-1:0]);
   assign hit_word = cache_word;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cache_valid <= 1'b0;
         cache_tag   <= '0;
         cache_word  <= 32'h0;
      end else if (state == S_IDLE && core_w) begin
         cache_valid <= 1'b0;
      end else if (state == S_BYTE && last_byte && !wr) begin
         cache_valid <= 1'b1;
         cache_tag   <= base;
         cache_word  <= asm_nxt;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_word = 32'h0;
`endif

   always_comb begin
      asm_nxt             = asm_word;
      asm_nxt[8*idx +: 8] = mem_din;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = hit ? S_ACK : S_BYTE;
         S_BYTE:  if (last_byte) state_nxt = S_ACK;
         S_ACK:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         base     <= '0;
         data     <= 32'h0;
         wr       <= 1'b0;
         idx      <= 2'd0;
         last_idx <= 2'd0;
         wait_cnt <= 4'd0;
         asm_word <= 32'h0;
         core_i   <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (hit) begin
                  core_i <= hit_word;
               end else begin
                  base     <= core_a[ADDR_W-1:0];
                  data     <= core_o;
                  wr       <= core_w;
                  // reads always fetch a full word; the core picks its own lanes
                  if (!core_w)           last_idx <= 2'd3;
                  else if (core_ws == 0) last_idx <= 2'd0;
                  else if (core_ws == 1) last_idx <= 2'd1;
                  else                   last_idx <= 2'd3;
                  idx      <= 2'd0;
                  asm_word <= 32'h0;
                  wait_cnt <= 4'(WAIT_STATES);
               end
            end
            S_BYTE: begin
               if (phase_end) begin
                  if (!wr) asm_word <= asm_nxt;
                  if (idx == last_idx) begin
                     core_i <= wr ? 32'h0 : asm_nxt;
                  end else begin
                     idx      <= idx + 2'd1;
                     wait_cnt <= 4'(WAIT_STATES);
                  end
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_byte_bus_bridge.sv
// Directed bench for byte_bus_bridge with SRAM models, a reference memory and an expected-data queue.
`timescale 1ns/1ps
module tb_byte_bus_bridge;
`ifdef BYTE_BUS_BRIDGE_FETCH_CACHE_EN
   localparam int HIT_LAT = 2;
`else
   localparam int HIT_LAT = 10;
`endif

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] core_a = 0, core_o = 0, core_i;
   logic [1:0]  core_ws = 0;
   logic        core_w = 0, core_ce, mem_we;
   logic [19:0] mem_a;
   logic [7:0]  mem_dout, mem_din;

   logic        rst4_n = 1'b0;
   logic [31:0] core_a4 = 32'd14, core_o4 = 0, core_i4;
   logic [1:0]  core_ws4 = 0;
   logic        core_w4 = 0, core_ce4, mem_we4;
   logic [3:0]  mem_a4;
   logic [7:0]  mem_dout4, mem_din4;

   logic [7:0]  ram [0:4095];
   logic [7:0]  ref_mem [0:4095];
   logic [7:0]  ram4 [0:15];
   logic [31:0] exp_q[$];

   int n_assert = 0, n_fail = 0;
   int we_cnt = 0;
   logic [19:0] last_wa;
   logic [7:0]  last_wd;
   logic        cur_w = 1'b0, prev_ce = 1'b0;

   always #5 clock = ~clock;

   byte_bus_bridge dut (
      .clock(clock), .rst_n(rst_n), .core_a(core_a), .core_o(core_o), .core_ws(core_ws),
      .core_w(core_w), .core_i(core_i), .core_ce(core_ce), .mem_a(mem_a),
      .mem_dout(mem_dout), .mem_din(mem_din), .mem_we(mem_we));

   byte_bus_bridge #(.ADDR_W(4), .WAIT_STATES(1)) dut4 (
      .clock(clock), .rst_n(rst4_n), .core_a(core_a4), .core_o(core_o4), .core_ws(core_ws4),
      .core_w(core_w4), .core_i(core_i4), .core_ce(core_ce4), .mem_a(mem_a4),
      .mem_dout(mem_dout4), .mem_din(mem_din4), .mem_we(mem_we4));

   assign mem_din  = ram[mem_a[11:0]];
   assign mem_din4 = ram4[mem_a4];

   always @(posedge clock) begin
      if (mem_we) begin
         ram[mem_a[11:0]] <= mem_dout;
         we_cnt  <= we_cnt + 1;
         last_wa <= mem_a;
         last_wd <= mem_dout;
      end
      if (mem_we4) ram4[mem_a4] <= mem_dout4;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin
      if (rst_n) begin
         check("ce_single_pulse", {31'h0, prev_ce & core_ce}, 32'h0);
         check("we_during_read", {31'h0, mem_we & ~cur_w}, 32'h0);
      end
      prev_ce <= rst_n ? core_ce : 1'b0;
   end

   // Called one tick after a posedge with the bridge in IDLE.
   task automatic step(input string tag, input logic [31:0] a, input logic [31:0] o,
                       input logic [1:0] ws, input logic w, input int lat);
      int cyc, n;
      bit got;
      logic [11:0] ra;
      logic [31:0] exp;
      core_a = a; core_o = o; core_ws = ws; core_w = w; cur_w = w;
      n = !w ? 4 : (ws == 2'd0 ? 1 : (ws == 2'd1 ? 2 : 4));
      if (w) begin
         for (int k = 0; k < n; k++) begin
            ra = a[11:0] + 12'(k);
            ref_mem[ra] = o[8*k +: 8];
         end
         exp_q.push_back(32'h0);
      end else begin
         for (int k = 0; k < 4; k++) begin
            ra = a[11:0] + 12'(k);
            exp[8*k +: 8] = ref_mem[ra];
         end
         exp_q.push_back(exp);
      end
      cyc = 0; got = 0;
      while (!got && cyc < 200) begin
         @(negedge clock);
         cyc++;
         got = core_ce;
      end
      check({tag, "_ce"}, {31'h0, got}, 32'h1);
      check({tag, "_lat"}, cyc, lat);
      exp = exp_q.pop_front();
      check({tag, "_data"}, core_i, exp);
      @(posedge clock); #1;
   endtask

   initial begin
      int we0, cyc;
      logic [3:0] seq[$];
      for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 7 + 3);
      ram[0] = 8'h78; ram[1] = 8'h56; ram[2] = 8'h34; ram[3] = 8'h12;
      ram[4] = 8'h11; ram[5] = 8'h22; ram[6] = 8'h33;
      ram[12'h20] = 8'hA0; ram[12'h21] = 8'hA1; ram[12'h22] = 8'hA2; ram[12'h23] = 8'hA3;
      for (int i = 0; i < 4096; i++) ref_mem[i] = ram[i];
      for (int i = 0; i < 16; i++) ram4[i] = 8'(8'h40 + i);

      repeat (3) @(posedge clock);
      #1;
      check("rst_ce", {31'h0, core_ce}, 32'h0);
      check("rst_core_i", core_i, 32'h0);
      check("rst_mem_a", {12'h0, mem_a}, 32'h0);
      check("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
      check("rst_mem_we", {31'h0, mem_we}, 32'h0);
      rst_n = 1'b1;

      // T1 word read
      step("t1_read", 32'h0, 32'h0, 2'd0, 1'b0, 10);

      // T2 byte store
      we0 = we_cnt;
      step("t2_store", 32'h5, 32'hAABBCCDD, 2'd0, 1'b1, 4);
      check("t2_we_cycles", we_cnt - we0, 32'd2);
      check("t2_addr", {12'h0, last_wa}, 32'h5);
      check("t2_dout", {24'h0, last_wd}, 32'hDD);
      check("t2_ram5", {24'h0, ram[5]}, 32'hDD);
      check("t2_ram4", {24'h0, ram[4]}, 32'h11);
      check("t2_ram6", {24'h0, ram[6]}, 32'h33);

      // T3 half store + readback
      step("t3_half", 32'h2, 32'h0000BEEF, 2'd1, 1'b1, 6);
      check("t3_ram2", {24'h0, ram[2]}, 32'hEF);
      check("t3_ram3", {24'h0, ram[3]}, 32'hBE);
      step("t3_read", 32'h0, 32'h0, 2'd0, 1'b0, 10);
      check("t3_word", core_i, 32'hBEEF5678);

      // Misaligned word store and readback
      step("mis_store", 32'h9, 32'h01020304, 2'd2, 1'b1, 10);
      step("mis_read", 32'h9, 32'h0, 2'd3, 1'b0, 10);

      // T4 wrap with ADDR_W=4
      rst4_n = 1'b1;
      cyc = 0;
      while (!core_ce4 && cyc < 50) begin
         @(negedge clock);
         cyc++;
         if (cyc == 2 || cyc == 4 || cyc == 6 || cyc == 8) seq.push_back(mem_a4);
      end
      check("t4_lat", cyc, 32'd10);
      check("t4_seq", (seq.size() == 4) ? {16'h0, seq[0], seq[1], seq[2], seq[3]} : 32'hFFFF_FFFF,
            32'h0000_EF01);
      check("t4_word", core_i4, 32'h41404F4E);
      rst4_n = 1'b0;

      // T5 reset during byte 2 of a word store
      core_a = 32'h20; core_o = 32'h44332211; core_ws = 2'd2; core_w = 1'b1; cur_w = 1'b1;
      repeat (6) @(negedge clock);
      check("t5_we_before", {31'h0, mem_we}, 32'h1);
      check("t5_addr_before", {12'h0, mem_a}, 32'h22);
      rst_n = 1'b0;
      #1;
      check("t5_we_drop", {31'h0, mem_we}, 32'h0);
      check("t5_ce_drop", {31'h0, core_ce}, 32'h0);
      ref_mem[12'h20] = 8'h11; ref_mem[12'h21] = 8'h22;
      repeat (2) @(posedge clock);
      #1;
      check("t5_core_i_rst", core_i, 32'h0);
      check("t5_ram22", {24'h0, ram[12'h22]}, 32'hA2);
      check("t5_ram23", {24'h0, ram[12'h23]}, 32'hA3);
      core_w = 1'b0; cur_w = 1'b0;
      rst_n = 1'b1;
      step("t5_read", 32'h20, 32'h0, 2'd0, 1'b0, 10);
      check("t5_word", core_i, 32'hA3A22211);

      // T6 read cache (hit latency depends on the build)
      step("t6_read1", 32'h100, 32'h0, 2'd0, 1'b0, 10);
      we0 = we_cnt;
      step("t6_read2", 32'h100, 32'h0, 2'd0, 1'b0, HIT_LAT);
      check("t6_no_we", we_cnt - we0, 32'd0);
      step("t6_store", 32'h100, 32'hCAFEF00D, 2'd2, 1'b1, 10);
      step("t6_read3", 32'h100, 32'h0, 2'd0, 1'b0, 10);
      check("t6_word", core_i, 32'hCAFEF00D);
      step("t6_read_other", 32'h0, 32'h0, 2'd0, 1'b0, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
